// File: rtl/axi2wb_pkg.sv
// rtl/axi2wb_pkg.sv - shared types and helpers for the AXI-Lite to Wishbone bridge
package axi2wb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WBEAT,
    S_WRSP,
    S_RBEAT,
    S_RRSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic lane_active(input logic [3:0] strb);
    return |strb;
  endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// rtl/wb_tmo_cnt.sv - Wishbone ack timeout counter, fires on the TMO-th strobe cycle
module wb_tmo_cnt #(
  parameter int TMO = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  if (TMO == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{i_clk, i_rst, i_run, i_clear};
    assign o_expired = 1'b0;
  end else begin : g_cnt
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign o_expired = i_run && (cnt_q == CW'(TMO - 1));

    always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!i_run || i_clear || o_expired) cnt_d = '0;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi2wb_wide.sv
// rtl/axi2wb_wide.sv - AXI4-Lite slave to 32-bit classic Wishbone master, one transaction in flight
module axi2wb_wide
  import axi2wb_pkg::*;
#(
  parameter int AW  = 12,
  parameter int IW  = 1,
  parameter int DW  = 64,
  parameter int TMO = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [AW-3:0]   o_wb_adr,
  output logic [31:0]     o_wb_dat,
  output logic [3:0]      o_wb_sel,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  input  logic [31:0]     i_wb_rdt,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [AW-1:0]   i_awaddr,
  input  logic [IW-1:0]   i_awid,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic            i_wvalid,
  output logic            o_wready,
  output logic [IW-1:0]   o_bid,
  output logic [1:0]      o_bresp,
  output logic            o_bvalid,
  input  logic            i_bready,
  input  logic [AW-1:0]   i_araddr,
  input  logic [IW-1:0]   i_arid,
  input  logic            i_arvalid,
  output logic            o_arready,
  output logic [DW-1:0]   o_rdata,
  output logic [IW-1:0]   o_rid,
  output logic [1:0]      o_rresp,
  output logic            o_rlast,
  output logic            o_rvalid,
  input  logic            i_rready
);

  localparam int NB = DW / 32;

  state_e           state_q;
  logic             awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [IW-1:0]    bid_q, rid_q;
  logic [AW-1:2]    addr_q;
  logic [DW-1:0]    wdata_q, rdata_q;
  logic [DW/8-1:0]  wstrb_q;
  logic [NB-1:0]    pend_q;
  logic             k_q;
  logic             cyc_q, stb_q, we_q, err_q, last_wr_q;
  logic [3:0]       sel_q;
  logic [AW-3:0]    adr_q;
  logic [31:0]      dat_q;

  function automatic logic first_lane(input logic [NB-1:0] m);
    logic r;
    r = 1'b0;
    for (int i = NB - 1; i >= 0; i--) if (m[i]) r = i[0];
    return r;
  endfunction

  function automatic logic [AW-3:0] beat_adr(input logic [AW-1:2] a, input logic k);
    return (NB == 2) ? {a[AW-1:3], k} : a;
  endfunction

  logic [NB-1:0] in_act, rem_mask;
  logic [AW-1:2] wr_addr;
  logic          wr_hs, wr_k, nxt_k, tmo_exp, beat_ack, beat_done, beat_err;
  logic          unused_addr;

  always_comb begin
    in_act = '0;
    for (int i = 0; i < NB; i++) in_act[i] = lane_active(i_wstrb[4*i +: 4]);
  end

  assign unused_addr = ^{i_awaddr[1:0], i_araddr[1:0]};
  assign wr_addr     = (state_q == S_IDLE) ? i_awaddr[AW-1:2] : addr_q;
  assign wr_hs       = wready_q && (state_q == S_IDLE || state_q == S_WDATA);
  assign wr_k        = first_lane(in_act);
  assign rem_mask    = pend_q & ~(NB'(1) << k_q);
  assign nxt_k       = first_lane(rem_mask);
  assign beat_ack    = i_wb_ack | i_wb_err;
  assign beat_done   = stb_q && (beat_ack || tmo_exp);
  // err wins over a simultaneous ack; no ack/err at all means the beat timed out
  assign beat_err    = i_wb_err || !beat_ack;

  wb_tmo_cnt #(.TMO(TMO)) u_tmo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (stb_q),
    .i_clear  (beat_ack),
    .o_expired(tmo_exp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      rid_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      pend_q    <= '0;
      k_q       <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            addr_q    <= i_awaddr[AW-1:2];
            bid_q     <= i_awid;
            if (!wready_q) state_q <= S_WDATA;
          end else if (arready_q) begin
            arready_q <= 1'b0;
            addr_q    <= i_araddr[AW-1:2];
            rid_q     <= i_arid;
            pend_q    <= '1;
            k_q       <= 1'b0;
            adr_q     <= beat_adr(i_araddr[AW-1:2], 1'b0);
            sel_q     <= 4'hF;
            we_q      <= 1'b0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            state_q   <= S_RBEAT;
          end else if (i_awvalid && (!i_arvalid || !last_wr_q)) begin
            awready_q <= 1'b1;
            wready_q  <= i_wvalid;
          end else if (i_arvalid) begin
            arready_q <= 1'b1;
          end
        end
        S_WDATA: begin
          if (wready_q)      wready_q <= 1'b0;
          else if (i_wvalid) wready_q <= 1'b1;
        end
        S_WBEAT, S_RBEAT: begin
          if (!stb_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
          end else if (beat_done) begin
            stb_q <= 1'b0;
            if (beat_err)  err_q <= 1'b1;
            if (!beat_ack) cyc_q <= 1'b0;
            if (state_q == S_RBEAT) rdata_q[32*k_q +: 32] <= beat_ack ? i_wb_rdt : 32'h0;
            if (rem_mask == '0) begin
              cyc_q <= 1'b0;
              we_q  <= 1'b0;
              sel_q <= '0;
              if (state_q == S_WBEAT) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                state_q  <= S_WRSP;
              end else begin
                rvalid_q <= 1'b1;
                rresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                state_q  <= S_RRSP;
              end
            end else begin
              pend_q <= rem_mask;
              k_q    <= nxt_k;
              adr_q  <= beat_adr(addr_q, nxt_k);
              if (state_q == S_WBEAT) begin
                sel_q <= wstrb_q[4*nxt_k +: 4];
                dat_q <= wdata_q[32*nxt_k +: 32];
              end
            end
          end
        end
        S_WRSP: begin
          if (i_bready) begin
            bvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_RRSP: begin
          if (i_rready) begin
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // W handshake launches the first active lane, or answers at once if no strobes
      if (wr_hs) begin
        wdata_q <= i_wdata;
        wstrb_q <= i_wstrb;
        if (|in_act) begin
          pend_q  <= in_act;
          k_q     <= wr_k;
          adr_q   <= beat_adr(wr_addr, wr_k);
          sel_q   <= i_wstrb[4*wr_k +: 4];
          dat_q   <= i_wdata[32*wr_k +: 32];
          we_q    <= 1'b1;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          state_q <= S_WBEAT;
        end else begin
          bvalid_q <= 1'b1;
          bresp_q  <= RESP_OKAY;
          state_q  <= S_WRSP;
        end
      end
    end
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;
  assign o_wb_we   = we_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_awready = awready_q;
  assign o_wready  = wready_q;
  assign o_arready = arready_q;
  assign o_bid     = bid_q;
  assign o_bresp   = bresp_q;
  assign o_bvalid  = bvalid_q;
  assign o_rdata   = rdata_q;
  assign o_rid     = rid_q;
  assign o_rresp   = rresp_q;
  assign o_rlast   = 1'b1;
  assign o_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi2wb_wide.sv
// tb/tb_axi2wb_wide.sv - directed bench for axi2wb_wide (DW=64, TMO=8)
module tb_axi2wb_wide;

  localparam int AW = 12, IW = 1, DW = 64, TMO = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic [AW-3:0]   o_wb_adr;
  logic [31:0]     o_wb_dat, i_wb_rdt;
  logic [3:0]      o_wb_sel;
  logic            o_wb_we, o_wb_cyc, o_wb_stb, i_wb_ack, i_wb_err;
  logic [AW-1:0]   i_awaddr = '0, i_araddr = '0;
  logic [IW-1:0]   i_awid = '0, i_arid = '0, o_bid, o_rid;
  logic            i_awvalid = 1'b0, i_wvalid = 1'b0, i_arvalid = 1'b0;
  logic            i_bready = 1'b1, i_rready = 1'b1;
  logic            o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_rlast;
  logic [DW-1:0]   i_wdata = '0, o_rdata;
  logic [DW/8-1:0] i_wstrb = '0;
  logic [1:0]      o_bresp, o_rresp;

  logic ack_en  = 1'b1;
  logic err0_en = 1'b0;

  // slave: zero-wait ack, optional err on even word addresses
  assign i_wb_err = err0_en && o_wb_cyc && o_wb_stb && !o_wb_adr[0];
  assign i_wb_ack = ack_en && o_wb_cyc && o_wb_stb && !i_wb_err;
  assign i_wb_rdt = o_wb_adr[0] ? 32'h2222_2222 : 32'h1111_1111;

  axi2wb_wide #(.AW(AW), .IW(IW), .DW(DW), .TMO(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arid(i_arid), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  int cycle = 0, cyc_cnt = 0, stb_cnt = 0;
  logic [31:0] b_adr[$], b_sel[$], b_dat[$], b_we[$];

  always @(posedge i_clk) cycle <= cycle + 1;

  always @(negedge i_clk) begin
    if (o_wb_cyc) cyc_cnt <= cyc_cnt + 1;
    if (o_wb_stb) stb_cnt <= stb_cnt + 1;
    if (o_wb_cyc && o_wb_stb && (i_wb_ack || i_wb_err)) begin
      b_adr.push_back(32'(o_wb_adr));
      b_sel.push_back(32'(o_wb_sel));
      b_dat.push_back(o_wb_dat);
      b_we.push_back(32'(o_wb_we));
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic id, input logic [63:0] d,
                          input logic [7:0] s, input int wdel, output logic [1:0] resp,
                          output logic bid_o, output int lat, output logic stb1);
    int n;
    int t_hs;
    logic wdone;
    i_awaddr = a; i_awid = id; i_wdata = d; i_wstrb = s;
    i_awvalid = 1'b1; i_wvalid = (wdel == 0);
    n = 0;
    while (!o_awready && n < 20) begin @(posedge i_clk); #1; n++; end
    check("aw_ready", 64'(o_awready), 64'd1);
    wdone = o_wready;
    t_hs = cycle;
    @(posedge i_clk); #1;
    i_awvalid = 1'b0;
    if (wdone) i_wvalid = 1'b0;
    else begin
      repeat (wdel) begin @(posedge i_clk); #1; end
      i_wvalid = 1'b1;
      n = 0;
      while (!o_wready && n < 20) begin @(posedge i_clk); #1; n++; end
      check("w_ready", 64'(o_wready), 64'd1);
      t_hs = cycle;
      @(posedge i_clk); #1;
      i_wvalid = 1'b0;
    end
    stb1 = o_wb_stb;
    n = 0;
    while (!o_bvalid && n < 60) begin @(posedge i_clk); #1; n++; end
    check("b_valid", 64'(o_bvalid), 64'd1);
    resp = o_bresp; bid_o = o_bid; lat = cycle - t_hs;
    @(posedge i_clk); #1;
  endtask

  task automatic do_read(input logic [11:0] a, input logic id, output logic [63:0] rd,
                         output logic [1:0] resp, output logic rid_o, output logic last);
    int n;
    i_araddr = a; i_arid = id; i_arvalid = 1'b1;
    n = 0;
    while (!o_arready && n < 20) begin @(posedge i_clk); #1; n++; end
    check("ar_ready", 64'(o_arready), 64'd1);
    @(posedge i_clk); #1;
    i_arvalid = 1'b0;
    n = 0;
    while (!o_rvalid && n < 100) begin @(posedge i_clk); #1; n++; end
    check("r_valid", 64'(o_rvalid), 64'd1);
    rd = o_rdata; resp = o_rresp; rid_o = o_rid; last = o_rlast;
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [1:0]  resp;
    logic        idv, stb1, last;
    logic [63:0] rd;
    int          lat, base, c0, s0, n, nrr;
    int          rr[4];

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 64'({o_awready, o_wready, o_arready, o_bvalid, o_rvalid}), 64'd0);
    check("rst_wb", 64'({o_wb_cyc, o_wb_stb, o_wb_we}), 64'd0);
    check("rst_adr_sel_dat", 64'({o_wb_adr, o_wb_sel, o_wb_dat}), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_resp_id", 64'({o_bresp, o_rresp, o_bid, o_rid}), 64'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // upper lane only
    base = b_adr.size();
    do_write(12'h010, 1'b1, 64'hAABBCCDD_11223344, 8'hF0, 0, resp, idv, lat, stb1);
    check("t1_beats", 64'(b_adr.size() - base), 64'd1);
    check("t1_adr", 64'(b_adr[base]), 64'h5);
    check("t1_sel", 64'(b_sel[base]), 64'hF);
    check("t1_dat", 64'(b_dat[base]), 64'hAABBCCDD);
    check("t1_we", 64'(b_we[base]), 64'd1);
    check("t1_bresp", 64'(resp), 64'd0);
    check("t1_bid", 64'(idv), 64'd1);
    check("t1_stb_t1", 64'(stb1), 64'd1);
    check("t1_lat", 64'(lat), 64'd2);

    base = b_adr.size();
    do_read(12'h020, 1'b1, rd, resp, idv, last);
    check("t2_beats", 64'(b_adr.size() - base), 64'd2);
    check("t2_adr0", 64'(b_adr[base]), 64'h8);
    check("t2_adr1", 64'(b_adr[base+1]), 64'h9);
    check("t2_sel", 64'({b_sel[base][3:0], b_sel[base+1][3:0]}), 64'hFF);
    check("t2_we", 64'(b_we[base] | b_we[base+1]), 64'd0);
    check("t2_rdata", rd, 64'h22222222_11111111);
    check("t2_rresp", 64'(resp), 64'd0);
    check("t2_rid", 64'(idv), 64'd1);
    check("t2_rlast", 64'(last), 64'd1);

    c0 = cyc_cnt;
    do_write(12'h018, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 0, resp, idv, lat, stb1);
    check("t3_no_cyc", 64'(cyc_cnt - c0), 64'd0);
    check("t3_lat_le2", 64'(lat <= 2), 64'd1);
    check("t3_bresp", 64'(resp), 64'd0);

    // W arrives two cycles after AW
    base = b_adr.size();
    do_write(12'h018, 1'b0, 64'h1234_5678_9ABC_DEF0, 8'h03, 2, resp, idv, lat, stb1);
    check("t3b_beats", 64'(b_adr.size() - base), 64'd1);
    check("t3b_adr", 64'(b_adr[base]), 64'h6);
    check("t3b_sel", 64'(b_sel[base]), 64'h3);
    check("t3b_dat", 64'(b_dat[base]), 64'h9ABCDEF0);
    check("t3b_lat", 64'(lat), 64'd2);

    err0_en = 1'b1;
    base = b_adr.size();
    do_read(12'h020, 1'b0, rd, resp, idv, last);
    err0_en = 1'b0;
    check("t4_beats", 64'(b_adr.size() - base), 64'd2);
    check("t4_adr1", 64'(b_adr[base+1]), 64'h9);
    check("t4_rresp", 64'(resp), 64'd2);

    ack_en = 1'b0;
    s0 = stb_cnt;
    do_write(12'h000, 1'b1, 64'h0, 8'h0F, 0, resp, idv, lat, stb1);
    check("t5_stb_cycles", 64'(stb_cnt - s0), 64'd8);
    check("t5_bresp", 64'(resp), 64'd2);
    ack_en = 1'b1;

    base = b_adr.size();
    do_write(12'h008, 1'b0, 64'hCAFEF00D_DEADBEEF, 8'hFF, 0, resp, idv, lat, stb1);
    check("t5r_beats", 64'(b_adr.size() - base), 64'd2);
    check("t5r_adr", 64'({b_adr[base][7:0], b_adr[base+1][7:0]}), 64'h0203);
    check("t5r_dat1", 64'(b_dat[base+1]), 64'hCAFEF00D);
    check("t5r_bresp", 64'(resp), 64'd0);

    ack_en = 1'b0;
    s0 = stb_cnt;
    do_read(12'h030, 1'b1, rd, resp, idv, last);
    ack_en = 1'b1;
    check("t6_stb_cycles", 64'(stb_cnt - s0), 64'd16);
    check("t6_rdata", rd, 64'd0);
    check("t6_rresp", 64'(resp), 64'd2);

    // both address channels held valid
    for (int i = 0; i < 4; i++) rr[i] = 9;
    i_awaddr = 12'h040; i_awid = 1'b0; i_wdata = 64'h5555_6666_7777_8888; i_wstrb = 8'h0F;
    i_araddr = 12'h048; i_arid = 1'b1;
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
    nrr = 0; n = 0;
    while (nrr < 4 && n < 200) begin
      @(posedge i_clk); #1; n++;
      if (o_awready && nrr < 4) begin rr[nrr] = 0; nrr++; end
      if (o_arready && nrr < 4) begin rr[nrr] = 1; nrr++; end
    end
    check("t7_grant0", 64'(rr[0]), 64'd0);
    check("t7_grant1", 64'(rr[1]), 64'd1);
    check("t7_grant2", 64'(rr[2]), 64'd0);
    check("t7_grant3", 64'(rr[3]), 64'd1);
    ack_en = 1'b0;
    n = 0;
    while (!(o_wb_stb && o_wb_we) && n < 200) begin @(posedge i_clk); #1; n++; end
    check("t7_in_wbeat", 64'(o_wb_stb && o_wb_we), 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("t7_rst_cyc", 64'(o_wb_cyc), 64'd0);
    check("t7_rst_outs", 64'({o_wb_stb, o_wb_we, o_awready, o_wready, o_arready, o_bvalid, o_rvalid}), 64'd0);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    ack_en = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
